// File: rtl/fdivsqrt_pkg.sv
// Shared types for the radix-4 sqrt datapath:
// udigit bit positions and the OTFC state enum.
package fdivsqrt_pkg;

  localparam int UD_P2 = 3;
  localparam int UD_P1 = 2;
  localparam int UD_N1 = 1;
  localparam int UD_N2 = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    DONE
  } otfc_state_t;

endpackage

// File: rtl/fdivsqrt_otfc4_if.sv
// Control/data bundle between the sqrt iteration
// sequencer (master) and the OTFC stage (slave).
interface fdivsqrt_otfc4_if #(
  parameter int DIVb = 28,
  parameter int CNTW = 5
);

  logic            start;
  logic            flush;
  logic [CNTW-1:0] Nsteps;
  logic [3:0]      udigit;
  logic            WNeg;
  logic            WZero;
  logic [DIVb+3:0] C;
  logic [DIVb+3:0] U;
  logic [DIVb+3:0] UM;
  logic [DIVb+3:0] Q;
  logic            busy;
  logic            done;

  modport master (
    output start, flush, Nsteps,
    output udigit, WNeg, WZero,
    input  C, U, UM, Q, busy, done
  );

  modport slave (
    input  start, flush, Nsteps,
    input  udigit, WNeg, WZero,
    output C, U, UM, Q, busy, done
  );

endinterface

// File: rtl/fdivsqrt_otfc4_step.sv
// One carry-free radix-4 on-the-fly conversion step:
// appends the selected digit to U/UM and advances C.
module fdivsqrt_otfc4_step
  import fdivsqrt_pkg::*;
#(
  parameter int DIVb = 28
) (
  input  logic [3:0]      udigit,
  input  logic [DIVb+3:0] U,
  input  logic [DIVb+3:0] UM,
  input  logic [DIVb+3:0] C,
  output logic [DIVb+3:0] Un,
  output logic [DIVb+3:0] UMn,
  output logic [DIVb+3:0] Cn
);

  logic [DIVb+3:0] k;
  logic [DIVb+3:0] k2;

  // k marks the weight 4^-j of the new digit
  assign Cn = {2'b11, C[DIVb+3:2]};
  assign k  = Cn & ~(Cn << 1);
  assign k2 = k << 1;

  // plain case gives 2,1,-1,-2 priority
  always_comb begin
    Un  = U;
    UMn = UM;
    case (1'b1)
      udigit[UD_P2]: begin
        Un  = U | k2;
        UMn = U | k;
      end
      udigit[UD_P1]: begin
        Un  = U | k;
        UMn = U;
      end
      udigit[UD_N1]: begin
        Un  = UM | k2 | k;
        UMn = UM | k2;
      end
      udigit[UD_N2]: begin
        Un  = UM | k2;
        UMn = UM | k;
      end
      default: begin
        Un  = U;
        UMn = UM | k2 | k;
      end
    endcase
  end

endmodule

// File: rtl/fdivsqrt_otfc4.sv
// Radix-4 OTFC root registers, step counter and FSM.
// FDIVSQRT_OTFC_EARLYTERM_EN: stop early on WZero.
module fdivsqrt_otfc4
  import fdivsqrt_pkg::*;
#(
  parameter int DIVb = 28,
  parameter int CNTW = 5
) (
  input logic             clk,
  input logic             reset,
  fdivsqrt_otfc4_if.slave io
);

  localparam int W = DIVb + 4;

  otfc_state_t     st_q, st_d;
  logic [W-1:0]    c_q, u_q, um_q, q_q;
  logic [W-1:0]    cn, un, umn;
  logic [CNTW-1:0] cnt_q, nst_q;
  logic            wz, last;

  fdivsqrt_otfc4_step #(.DIVb(DIVb)) u_step (
    .udigit (io.udigit),
    .U      (u_q),
    .UM     (um_q),
    .C      (c_q),
    .Un     (un),
    .UMn    (umn),
    .Cn     (cn)
  );

`ifdef FDIVSQRT_OTFC_EARLYTERM_EN
  assign wz = io.WZero;
`else
  assign wz = 1'b0;
`endif

  assign last = (CNTW'(cnt_q + 1'b1) == nst_q) | wz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (io.flush) begin
      st_d = IDLE;
    end else begin
      unique case (st_q)
        IDLE: if (io.start) st_d = LOAD;
        LOAD: st_d = (nst_q == '0) ? DONE : BUSY;
        BUSY: if (last) st_d = DONE;
        DONE: st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q   <= '0;
      u_q   <= '0;
      um_q  <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      nst_q <= '0;
    end else if (!io.flush) begin
      if (st_q == IDLE && io.start) begin
        c_q   <= {4'b1111, {DIVb{1'b0}}};
        u_q   <= W'(1) << DIVb;
        um_q  <= '0;
        cnt_q <= '0;
        nst_q <= io.Nsteps;
      end else if (st_q == LOAD && nst_q == '0) begin
        q_q <= u_q;
      end else if (st_q == BUSY) begin
        c_q   <= cn;
        u_q   <= un;
        um_q  <= umn;
        cnt_q <= cnt_q + 1'b1;
        // zero residual: U is exact, sign is moot
        if (last) q_q <= (io.WNeg & ~wz) ? umn : un;
      end
    end
  end

  always_comb begin
    io.C    = c_q;
    io.U    = u_q;
    io.UM   = um_q;
    io.Q    = q_q;
    io.busy = (st_q == BUSY);
    io.done = (st_q == DONE) & ~io.flush;
  end

endmodule

// File: tb/tb_fdivsqrt_otfc4.sv
// Directed + table-driven bench for fdivsqrt_otfc4
// (DIVb = 28, default build).
module tb_fdivsqrt_otfc4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fdivsqrt_otfc4_if #(.DIVb(28), .CNTW(5)) io ();

  fdivsqrt_otfc4 #(.DIVb(28), .CNTW(5)) dut (
    .clk   (clk),
    .reset (rst),
    .io    (io.slave)
  );

  typedef struct {
    int          n;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic        wn;
    logic [31:0] eu;
    logic [31:0] eum;
    logic [31:0] ec;
    logic [31:0] eq;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // start at edge 0, feed digits, stop at the done cycle
  task automatic run(input int n,
                     input logic [3:0] dg[16],
                     input logic wn,
                     output int dcyc);
    dcyc = -1;
    io.start  = 1'b1;
    io.Nsteps = n[4:0];
    io.WNeg   = wn;
    io.udigit = 4'b0;
    cyc();
    io.start = 1'b0;
    for (int c = 1; c < n + 6 && dcyc < 0; c++) begin
      io.udigit = (c >= 2 && c - 2 < n) ? dg[c-2] : 4'b0;
      if (io.done) dcyc = c;
      else cyc();
    end
    io.udigit = 4'b0;
  endtask

  initial begin
    logic [3:0] dg[16];
    logic [3:0] oh[5];
    int         dv[5];
    int         dcyc, r, w, sel;
    logic       seen;

    tv[0] = '{1, 4'b1000, 4'b0000, 1'b0, 32'h18000000,
              32'h14000000, 32'hFC000000, 32'h18000000};
    tv[1] = '{2, 4'b0100, 4'b0010, 1'b1, 32'h13000000,
              32'h12000000, 32'hFF000000, 32'h12000000};
    tv[2] = '{1, 4'b0000, 4'b0000, 1'b0, 32'h10000000,
              32'h0C000000, 32'hFC000000, 32'h10000000};
    tv[3] = '{0, 4'b0000, 4'b0000, 1'b0, 32'h10000000,
              32'h00000000, 32'hF0000000, 32'h10000000};
    tv[4] = '{1, 4'b0001, 4'b0000, 1'b1, 32'h08000000,
              32'h04000000, 32'hFC000000, 32'h04000000};
    tv[5] = '{2, 4'b0010, 4'b1000, 1'b0, 32'h0E000000,
              32'h0D000000, 32'hFF000000, 32'h0E000000};
    oh = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    dv = '{0, 2, 1, -1, -2};

    io.start  = 1'b0;
    io.flush  = 1'b0;
    io.Nsteps = '0;
    io.udigit = '0;
    io.WNeg   = 1'b0;
    io.WZero  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_U", io.U, 32'h0);
    chk("rst_C", io.C, 32'h0);
    chk("rst_busy", {31'b0, io.busy}, 32'h0);
    chk("rst_done", {31'b0, io.done}, 32'h0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      foreach (dg[k]) dg[k] = 4'b0;
      dg[0] = tv[i].d0;
      dg[1] = tv[i].d1;
      run(tv[i].n, dg, tv[i].wn, dcyc);
      chk($sformatf("v%0d_lat", i), dcyc, tv[i].n + 2);
      chk($sformatf("v%0d_U", i), io.U, tv[i].eu);
      chk($sformatf("v%0d_UM", i), io.UM, tv[i].eum);
      chk($sformatf("v%0d_C", i), io.C, tv[i].ec);
      chk($sformatf("v%0d_Q", i), io.Q, tv[i].eq);
      cyc();
      chk($sformatf("v%0d_idle", i),
          {30'b0, io.busy, io.done}, 32'h0);
    end

    // 14 random digits against an accumulating model
    io.start  = 1'b1;
    io.Nsteps = 5'd14;
    io.WNeg   = 1'b1;
    cyc();
    io.start = 1'b0;
    cyc();
    r = 32'h10000000;
    for (int j = 1; j <= 14; j++) begin
      sel = $urandom_range(0, 4);
      io.udigit = oh[sel];
      w = 32'h10000000 >> (2 * j);
      r = r + dv[sel] * w;
      cyc();
      chk($sformatf("rnd%0d_U", j), io.U, r);
      chk($sformatf("rnd%0d_W", j), io.U - io.UM, w);
    end
    io.udigit = 4'b0;
    chk("rnd_done", {31'b0, io.done}, 32'h1);
    chk("rnd_Q", io.Q, r - 1);
    cyc();

    // flush in third BUSY cycle (cycle 4)
    io.udigit = 4'b0100;
    io.start  = 1'b1;
    io.Nsteps = 5'd5;
    cyc();
    io.start = 1'b0;
    repeat (3) cyc();
    io.flush = 1'b1;
    chk("fl_busy", {31'b0, io.busy}, 32'h1);
    cyc();
    io.flush = 1'b0;
    chk("fl_idle", {30'b0, io.busy, io.done}, 32'h0);
    chk("fl_U", io.U, 32'h15000000);
    seen = 1'b0;
    repeat (6) begin
      cyc();
      seen |= io.done | io.busy;
    end
    chk("fl_nodone", {31'b0, seen}, 32'h0);

    // start while BUSY is ignored
    io.start  = 1'b1;
    io.Nsteps = 5'd3;
    cyc();
    io.start = 1'b0;
    cyc();
    io.start  = 1'b1;
    io.Nsteps = 5'd1;
    cyc();
    io.start = 1'b0;
    cyc();
    chk("sb_nodone4", {31'b0, io.done}, 32'h0);
    cyc();
    chk("sb_done5", {31'b0, io.done}, 32'h1);
    chk("sb_U", io.U, 32'h15400000);
    io.udigit = 4'b0;
    repeat (2) cyc();

    // async reset mid-BUSY
    io.start  = 1'b1;
    io.Nsteps = 5'd5;
    io.udigit = 4'b1000;
    cyc();
    io.start = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("ar_U", io.U, 32'h0);
    chk("ar_UM", io.UM, 32'h0);
    chk("ar_C", io.C, 32'h0);
    chk("ar_Q", io.Q, 32'h0);
    chk("ar_bd", {30'b0, io.busy, io.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    io.udigit = 4'b0;
    seen = 1'b0;
    repeat (8) begin
      cyc();
      seen |= io.done;
    end
    chk("ar_nodone", {31'b0, seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
